aes_dec_round_ctrl: RTL

AES_DEC_ROUND_CTRL -- requirements
Module: aes_dec_round_ctrl

---
 rtl/aes_dec_round_ctrl_pkg.sv | 15 +
 rtl/aes_dec_round_ctrl_rcon.sv | 25 ++
 rtl/aes_dec_round_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/aes_dec_round_ctrl_pkg.sv
// Shared AES definitions: round count and round-sequencer state encoding used by
// the encryption and decryption controllers.
package aes_dec_round_ctrl_pkg;

  localparam int unsigned AES_NUM_ROUNDS = 10;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StInit  = 3'd1,
    StRound = 3'd2,
    StFinal = 3'd3,
    StDone  = 3'd4
  } aes_round_state_e;

endpackage

// File: rtl/aes_dec_round_ctrl_rcon.sv
// Inverse-rcon lookup: maps a decryption step (1..10) to the round constant the key
// schedule must undo at that step; other indices return zero.
module aes_dec_round_ctrl_rcon (
  input  logic [7:0] rcon_idx,
  output logic [7:0] rcon
);

  always_comb begin
    rcon = 8'h00;
    unique case (rcon_idx)
      8'd1:    rcon = 8'h36;
      8'd2:    rcon = 8'h1b;
      8'd3:    rcon = 8'h80;
      8'd4:    rcon = 8'h40;
      8'd5:    rcon = 8'h20;
      8'd6:    rcon = 8'h10;
      8'd7:    rcon = 8'h08;
      8'd8:    rcon = 8'h04;
      8'd9:    rcon = 8'h02;
      8'd10:   rcon = 8'h01;
      default: rcon = 8'h00;
    endcase
  end

endmodule

// File: rtl/aes_dec_round_ctrl.sv
// AES decryption round sequencer: start handshake, key load, NUM_ROUNDS inverse
// rounds (last without InvMixColumns) and a held result handshake.
module aes_dec_round_ctrl
  import aes_dec_round_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic       stall,
  output logic       key_load,
  output logic       first_round,
  output logic       round_en,
  output logic       last_round,
  output logic [3:0] round_cnt,
  output logic [7:0] rcon_idx,
  output logic [7:0] rcon,
  output logic       busy,
  output logic       done_valid,
  input  logic       done_ready
);

  localparam logic [3:0] PenultCnt = 4'(NUM_ROUNDS - 1);

  aes_round_state_e state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             in_round;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_valid) begin
          state_d = StInit;
          cnt_d   = 4'd0;
        end
      end
      StInit: begin
        if (!stall) begin
          state_d = StRound;
          cnt_d   = 4'd1;
        end
      end
      StRound: begin
        if (!stall) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == PenultCnt) state_d = StFinal;
        end
      end
      StFinal: begin
        if (!stall) state_d = StDone;
      end
      StDone: begin
        // Counter is cleared on the way out so IDLE always reports step 0.
        if (done_ready) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    in_round    = (state_q == StRound) || (state_q == StFinal);
    start_ready = (state_q == StIdle);
    busy        = (state_q != StIdle);
    first_round = (state_q == StInit);
    // Stall only gates the datapath strobes; all other outputs stay state-decoded.
    key_load    = (state_q == StInit) && !stall;
    round_en    = in_round && !stall;
    last_round  = (state_q == StFinal);
    done_valid  = (state_q == StDone);
    round_cnt   = cnt_q;
    rcon_idx    = in_round ? {4'h0, cnt_q} : 8'h00;
  end

  aes_dec_round_ctrl_rcon u_rcon (
    .rcon_idx (rcon_idx),
    .rcon     (rcon)
  );

endmodule
